dmg_line_fetch: RTL and testbench

- Upstream pixel source for the DMG LCD controller.
- Prefetches one display row per line from a byte-wide, 2bpp packed framebuffer RAM into a ping-pong line buffer, using a req/ack handshake.
- Returns the 2-bit pixel for the controller's current (pix_x, pix_y), with one cycle of latency. pix_x/pix_y are the controller's offset position outputs (xpos_out/ypos_out).
- Runs entirely in the clk_8m domain; the controller and the RAM arbiter are its only neighbours.

---
 rtl/dmg_pkg.sv | 24 ++
 rtl/dmg_line_bank.sv | 57 +++++
 rtl/dmg_line_fetch.sv | 160 ++++++++++++++++
 tb/tb_dmg_line_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmg_pkg.sv
// Shared definitions for the DMG line fetcher: display geometry, fetch FSM
// states and the row-to-byte-offset helper.
package dmg_pkg;

    localparam int COLS          = 160;
    localparam int ROWS          = 144;
    localparam int BYTES_PER_ROW = COLS / 4;
    localparam int COL_W         = 6;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        DRAIN
    } fetch_state_t;

    // row * 40 built from two shifts; callers truncate to their address width
    function automatic logic [15:0] row_offset(input logic [7:0] row);
        logic [15:0] r;
        r = {8'd0, row};
        return (r << 5) + (r << 3);
    endfunction

endpackage

// File: rtl/dmg_line_bank.sv
// Ping-pong line buffer: one bank is displayed while the other is filled.
// A swap exchanges roles and invalidates the bank that becomes the fill bank.
module dmg_line_bank
    import dmg_pkg::*;
(
    input  logic             clk_8m,
    input  logic             rst,
    input  logic             swap,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [7:0]       wr_data,
    input  logic             set_valid,
    input  logic [COL_W-1:0] rd_col,
    output logic [7:0]       rd_data,
    output logic             rd_valid
);

    logic [7:0] mem [2][BYTES_PER_ROW];
    logic       disp_sel;
    logic       fill_sel;
    logic [1:0] valid;

    assign fill_sel = ~disp_sel;
    assign rd_valid = valid[disp_sel];

    // Bank roles and per-bank valid flags
    // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            disp_sel <= 1'b0;
            valid    <= 2'b00;
        end else if (swap) begin
            disp_sel        <= ~disp_sel;
            valid[disp_sel] <= 1'b0;
        end else if (set_valid) begin
            valid[fill_sel] <= 1'b1;
        end
    end

    // Byte storage, written only from fetched RAM data
    // NOTE: storage is deliberately not reset; the valid flags gate every read, and a reset here would block RAM inference.
    always_ff @(posedge clk_8m) begin
        if (wr_en) begin
            mem[fill_sel][wr_col] <= wr_data;
        end
    end

    // Display-bank read, guarded against columns past the end of the row
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_data = 8'h00;
        if (rd_col < COL_W'(BYTES_PER_ROW)) begin
            rd_data = mem[disp_sel][rd_col];
        end
    end

endmodule

// File: rtl/dmg_line_fetch.sv
// Line prefetcher for the DMG LCD controller: on each row change it fetches
// the following row from the packed 2bpp framebuffer into the fill bank and
// serves pixels of the current row from the display bank.
module dmg_line_fetch
    import dmg_pkg::*;
#(
    parameter int            AW      = 13,
    parameter logic [AW-1:0] FB_BASE = '0
) (
    input  logic          clk_8m,
    input  logic          rst,
    input  logic [8:0]    pix_x,
    input  logic [7:0]    pix_y,
    output logic [1:0]    pix_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic          fetch_underrun
);

    fetch_state_t     state_q, state_d;
    logic [7:0]       prev_y, row_q, next_row, tgt_row;
    logic             line_chg, tgt_ok;
    logic [COL_W-1:0] col_q, col_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             load_addr, bank_we, bank_set_valid, underrun_set;
    logic [7:0]       rd_data;
    logic             rd_valid;

    assign line_chg = (pix_y != prev_y);
    assign next_row = pix_y + 8'd1;
    // Row the next fetch targets; a line change this cycle supersedes the held row
    assign tgt_row  = line_chg ? next_row : row_q;
    assign tgt_ok   = (tgt_row < 8'(ROWS));

    assign mem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign mem_addr = addr_q;

    // Track the controller row and latch the row to prefetch
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            prev_y <= 8'hFF;
            row_q  <= 8'h00;
        end else begin
            prev_y <= pix_y;
            if (line_chg) begin
                row_q <= next_row;
            end
        end
    end

    // Fetch FSM state, column, held address and sticky underrun flag
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state_q        <= IDLE;
            col_q          <= '0;
            addr_q         <= '0;
            fetch_underrun <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            if (underrun_set) begin
                fetch_underrun <= 1'b1;
            end
        end
    end

    // Next-state, bank write and address load decisions
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        addr_d         = addr_q;
        load_addr      = 1'b0;
        bank_we        = 1'b0;
        bank_set_valid = 1'b0;
        underrun_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_chg && tgt_ok) begin
                    state_d   = REQ;
                    col_d     = '0;
                    load_addr = 1'b1;
                end
            end
            REQ: begin
                if (line_chg) begin
                    underrun_set = 1'b1;
                    if (mem_ack) begin
                        // The ack retires the outstanding read; its byte is dropped
                        state_d   = tgt_ok ? REQ : IDLE;
                        col_d     = '0;
                        load_addr = tgt_ok;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ack) begin
                    bank_we = 1'b1;
                    if (col_q == COL_W'(BYTES_PER_ROW - 1)) begin
                        bank_set_valid = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (line_chg) begin
                    underrun_set = 1'b1;
                    state_d      = tgt_ok ? REQ : IDLE;
                    col_d        = '0;
                    load_addr    = tgt_ok;
                end else begin
                    state_d   = REQ;
                    load_addr = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d   = tgt_ok ? REQ : IDLE;
                    col_d     = '0;
                    load_addr = tgt_ok;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_addr) begin
            addr_d = FB_BASE + AW'(row_offset(tgt_row)) + AW'(col_d);
        end
    end

    dmg_line_bank u_bank (
        .clk_8m    (clk_8m),
        .rst       (rst),
        .swap      (line_chg),
        .wr_en     (bank_we),
        .wr_col    (col_q),
        .wr_data   (mem_rdata),
        .set_valid (bank_set_valid),
        .rd_col    (pix_x[7:2]),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    // Registered pixel select; blank outside the visible columns or on an invalid bank
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            pix_data <= 2'b00;
        end else if ((pix_x < 9'(COLS)) && rd_valid) begin
            pix_data <= rd_data[{pix_x[1:0], 1'b0} +: 2];
        end else begin
            pix_data <= 2'b00;
        end
    end

endmodule

// File: tb/tb_dmg_line_fetch.sv
// Self-checking bench for dmg_line_fetch: a RAM responder with adjustable
// ack latency, an address log, and a pixel scoreboard per scenario.
module tb_dmg_line_fetch;

    logic        clk_8m = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  pix_x = 9'd0;
    logic [7:0]  pix_y = 8'd254;
    logic [1:0]  pix_data;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        fetch_underrun;

    int          n_vec = 0;
    int          n_err = 0;
    int          ram_lat = 2;
    bit          ram_auto = 1'b1;
    int          ack_seen = 0;
    int          wait_cnt = 0;
    logic        req_prev = 1'b0;
    logic [12:0] addr_prev = '0;
    logic [12:0] obs_addr_q[$];
    int          exp_pix_q[$];

    dmg_line_fetch dut (
        .clk_8m         (clk_8m),
        .rst            (rst),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_data       (pix_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .fetch_underrun (fetch_underrun)
    );

    always #5 clk_8m = ~clk_8m;

    function automatic logic [7:0] ram_byte(input int a);
        if (a == 0) return 8'hE4;
        return 8'(((a % 256) ^ 'h5A) ^ (a / 256));
    endfunction

    function automatic int pix_model(input int row, input int x);
        int b;
        if (x >= 160) return 0;
        b = int'(ram_byte(row * 40 + x / 4));
        return (b >> (2 * (x % 4))) & 3;
    endfunction

    // RAM responder: logs each new request, acks after ram_lat cycles
    initial forever begin
        @(negedge clk_8m);
        if (mem_req && (!req_prev || mem_addr != addr_prev)) begin
            obs_addr_q.push_back(mem_addr);
            wait_cnt = 0;
        end
        req_prev  = mem_req;
        addr_prev = mem_addr;
        if (ram_auto) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                wait_cnt++;
                if (wait_cnt >= ram_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ram_byte(int'(mem_addr));
                    wait_cnt  = 0;
                end
            end
        end
    end

    // Count completed read handshakes
    initial forever begin
        @(posedge clk_8m);
        if (mem_req && mem_ack) ack_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_acks(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_8m);
            if (ack_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_8m);
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        pix_y = 8'd254;
        repeat (3) @(negedge clk_8m);
        n_vec++; if (pix_data !== 2'd0) begin n_err++; $display("FAIL reset pix_data: got %0d exp 0", pix_data); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset mem_req: got %0b exp 0", mem_req); end
        n_vec++; if (mem_addr !== 13'd0) begin n_err++; $display("FAIL reset mem_addr: got %0d exp 0", mem_addr); end
        n_vec++; if (fetch_underrun !== 1'b0) begin n_err++; $display("FAIL reset underrun: got %0b exp 0", fetch_underrun); end
        rst = 1'b0;
    endtask

    task automatic test_vblank_idle();
        pix_x = 9'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_8m);
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL vblank_idle mem_req cyc%0d: got %0b exp 0", i, mem_req); end
            n_vec++; if (pix_data !== 2'd0) begin n_err++; $display("FAIL vblank_idle pix_data cyc%0d: got %0d exp 0", i, pix_data); end
        end
        n_vec++; if (obs_addr_q.size() != 0) begin n_err++; $display("FAIL vblank_idle reads: got %0d exp 0", obs_addr_q.size()); end
    endtask

    task automatic test_fetch_row0();
        bit ok;
        int base;
        int e;
        ram_lat = 2;
        obs_addr_q.delete();
        base = ack_seen;
        @(negedge clk_8m);
        pix_y = 8'd255;
        wait_acks(base + 40, 600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fetch_row0 timeout: got %0d acks exp 40", ack_seen - base); end
        n_vec++; if (obs_addr_q.size() != 40) begin n_err++; $display("FAIL fetch_row0 req count: got %0d exp 40", obs_addr_q.size()); end
        for (int c = 0; c < 40 && c < obs_addr_q.size(); c++) begin
            n_vec++; if (obs_addr_q[c] !== 13'(c)) begin n_err++; $display("FAIL fetch_row0 addr[%0d]: got %0d exp %0d", c, obs_addr_q[c], c); end
        end
        // Row 0 sits in the fill bank; the displayed bank is still invalid
        exp_pix_q.delete();
        for (int x = 0; x <= 4; x++) begin
            @(negedge clk_8m);
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL row255 pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 3) begin pix_x = 9'(x); exp_pix_q.push_back(0); end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_8m);
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle no-read cyc%0d: got %0b exp 0", i, mem_req); end
        end
    endtask

    task automatic test_pixels_row0();
        bit ok;
        int base;
        int e;
        obs_addr_q.delete();
        base = ack_seen;
        @(negedge clk_8m);
        pix_y = 8'd0;
        repeat (2) @(negedge clk_8m);
        exp_pix_q.delete();
        for (int x = 0; x <= 171; x++) begin
            @(negedge clk_8m);
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL row0 pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 170) begin pix_x = 9'(x); exp_pix_q.push_back(pix_model(0, x)); end
        end
        wait_acks(base + 40, 600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL row1 fetch timeout: got %0d acks exp 40", ack_seen - base); end
        n_vec++; if (obs_addr_q.size() < 40 || obs_addr_q[0] !== 13'd40 || obs_addr_q[39] !== 13'd79) begin
            n_err++; $display("FAIL row1 addr range: got %0d reqs first %0d exp 40 reqs 40..79", obs_addr_q.size(), obs_addr_q.size() > 0 ? obs_addr_q[0] : 13'd0);
        end
    endtask

    task automatic test_vblank_edge();
        bit ok;
        int base;
        int e;
        int n_before;
        ram_lat = 1;
        obs_addr_q.delete();
        base = ack_seen;
        @(negedge clk_8m);
        pix_y = 8'd142;
        wait_acks(base + 40, 600, ok);
        n_vec++; if (!ok || obs_addr_q.size() == 0 || obs_addr_q[0] !== 13'd5720) begin
            n_err++; $display("FAIL row143 fetch: got ok=%0b first %0d exp ok=1 first 5720", ok, obs_addr_q.size() > 0 ? obs_addr_q[0] : 13'd0);
        end
        @(negedge clk_8m);
        pix_y = 8'd143;
        n_before = obs_addr_q.size();
        exp_pix_q.delete();
        for (int x = 152; x <= 162; x++) begin
            @(negedge clk_8m);
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL row144 no-fetch mem_req: got %0b exp 0", mem_req); end
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL row143 pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 161) begin pix_x = 9'(x); exp_pix_q.push_back(pix_model(143, x)); end
        end
        n_vec++; if (obs_addr_q.size() != n_before) begin n_err++; $display("FAIL row144 reads: got %0d exp %0d", obs_addr_q.size(), n_before); end
        ram_lat = 2;
        obs_addr_q.delete();
        base = ack_seen;
        @(negedge clk_8m);
        pix_y = 8'd255;
        wait_req(10, ok);
        n_vec++; if (!ok || mem_addr !== 13'd0) begin n_err++; $display("FAIL wrap fetch start: got req=%0b addr %0d exp req=1 addr 0", ok, mem_addr); end
        wait_acks(base + 40, 600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap fetch timeout: got %0d acks exp 40", ack_seen - base); end
        n_vec++; if (fetch_underrun !== 1'b0) begin n_err++; $display("FAIL no underrun yet: got %0b exp 0", fetch_underrun); end
    endtask

    task automatic test_underrun_drain();
        bit ok;
        int base;
        int e;
        ram_lat = 30;
        base = ack_seen;
        @(negedge clk_8m);
        pix_y = 8'd0;
        wait_acks(base + 10, 1000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL underrun 10 acks timeout: got %0d exp 10", ack_seen - base); end
        repeat (5) @(negedge clk_8m);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 13'd50) begin n_err++; $display("FAIL pre-drain req: got req=%0b addr %0d exp req=1 addr 50", mem_req, mem_addr); end
        pix_y = 8'd1;
        @(negedge clk_8m);
        n_vec++; if (fetch_underrun !== 1'b1) begin n_err++; $display("FAIL underrun flag: got %0b exp 1", fetch_underrun); end
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 13'd50) begin n_err++; $display("FAIL drain hold: got req=%0b addr %0d exp req=1 addr 50", mem_req, mem_addr); end
        wait_acks(base + 11, 100, ok);
        n_vec++; if (!ok || mem_req !== 1'b1 || mem_addr !== 13'd80) begin
            n_err++; $display("FAIL drain restart: got ok=%0b req=%0b addr %0d exp ok=1 req=1 addr 80", ok, mem_req, mem_addr);
        end
        exp_pix_q.delete();
        for (int x = 0; x <= 8; x++) begin
            @(negedge clk_8m);
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL partial row1 pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 7) begin pix_x = 9'(x); exp_pix_q.push_back(0); end
        end
        ram_lat = 1;
        wait_acks(base + 51, 600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL row2 fetch timeout: got %0d acks exp 51", ack_seen - base); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int e;
        @(negedge clk_8m);
        ram_auto = 1'b0;
        mem_ack  = 1'b0;
        pix_y    = 8'd2;
        exp_pix_q.delete();
        for (int x = 0; x <= 8; x++) begin
            @(negedge clk_8m);
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL row2 pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 7) begin pix_x = 9'(x); exp_pix_q.push_back(pix_model(2, x)); end
        end
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 13'd120) begin n_err++; $display("FAIL row3 req: got req=%0b addr %0d exp req=1 addr 120", mem_req, mem_addr); end
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
        pix_y     = 8'd3;
        @(negedge clk_8m);
        mem_ack = 1'b0;
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 13'd160) begin
            n_err++; $display("FAIL coincident ack no drain: got req=%0b addr %0d exp req=1 addr 160", mem_req, mem_addr);
        end
        n_vec++; if (fetch_underrun !== 1'b1) begin n_err++; $display("FAIL underrun sticky: got %0b exp 1", fetch_underrun); end
        ram_auto = 1'b1;
        wait_req(2, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        int e;
        ram_lat = 1;
        base = ack_seen;
        wait_acks(base + 40, 600, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL row4 fetch timeout: got %0d acks exp 40", ack_seen - base); end
        ram_lat = 30;
        @(negedge clk_8m);
        pix_y = 8'd4;
        exp_pix_q.delete();
        for (int x = 0; x <= 4; x++) begin
            @(negedge clk_8m);
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL row4 pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 3) begin pix_x = 9'(x); exp_pix_q.push_back(pix_model(4, x)); end
        end
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid-REQ before reset: got %0b exp 1", mem_req); end
        rst   = 1'b1;
        pix_y = 8'd255;
        @(negedge clk_8m);
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset drops mem_req: got %0b exp 0", mem_req); end
        n_vec++; if (fetch_underrun !== 1'b0) begin n_err++; $display("FAIL reset clears underrun: got %0b exp 0", fetch_underrun); end
        n_vec++; if (mem_addr !== 13'd0 || pix_data !== 2'd0) begin n_err++; $display("FAIL reset addr/pix: got %0d/%0d exp 0/0", mem_addr, pix_data); end
        rst = 1'b0;
        @(negedge clk_8m);
        pix_y = 8'd143;
        exp_pix_q.delete();
        for (int x = 0; x <= 4; x++) begin
            @(negedge clk_8m);
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL post-reset idle: got %0b exp 0", mem_req); end
            if (exp_pix_q.size() > 0) begin
                e = exp_pix_q.pop_front();
                n_vec++; if (pix_data !== 2'(e)) begin n_err++; $display("FAIL post-reset bank pix x%0d: got %0d exp %0d", x - 1, pix_data, e); end
            end
            if (x <= 3) begin pix_x = 9'(x); exp_pix_q.push_back(0); end
        end
    endtask

    initial begin
        test_reset();
        test_vblank_idle();
        test_fetch_row0();
        test_pixels_row0();
        test_vblank_edge();
        test_underrun_drain();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
